dds_phase_engine: RTL
=====================

# dds_phase_engine

Receiving end of the DDS modulator's configuration AXI-Stream. It accepts the 72-bit config beats (phase increment, phase offset, resync), runs a 30-bit phase accumulator and emits one phase sample per transfer on an AXI-Stream master with backpressure. It sits where the DDS IP core's config port sits and serves as a synthesizable phase source and as a bit-accurate model for checking modulator output.

## Interface
- PHASE_BITS, 30, accumulator, increment and offset width; fixed by the config word format.
- OUT_BITS, 16, output phase width; the top OUT_BITS of the phase, truncated.
- clk_i  in  1  single clock; all logic on its rising edge.
- resetn_i  in  1  reset, asynchronous and active-low.
- en_i  in  1  enables new sample generation.
- s_axis_config_tdata  in  72  bits [29:0] = pinc, [61:32] = offset, [64] = resync; bits 31:30, 63:62 and 71:65 are ignored.
- s_axis_config_tvalid  in  1  config beat valid.
- s_axis_config_tlast  in  1  marks the last beat of a debug packet.
- s_axis_config_tready  out  1  config ready.
- m_axis_phase_tdata  out  OUT_BITS  phase sample.
- m_axis_phase_tuser  out  1  sample produced while resync was set.
- m_axis_phase_tvalid  out  1  sample valid.
- m_axis_phase_tready  in  1  downstream ready.
- cfg_beats_o  out  16  wrapping count of accepted config beats.
- cfg_packets_o  out  16  wrapping count of accepted beats with tlast = 1.

## Operation
- **Config path**
  - s_axis_config_tready is a register: 0 in reset, 1 from the first clock edge after reset release, and 1 permanently afterwards. No beat is ever dropped.
  - On an accepted beat (tvalid & tready), pinc_r, offset_r and resync_r load from tdata, and cfg_beats_o increments.
  - If tlast is also 1, cfg_packets_o increments in the same cycle.
  - Both counters wrap from 0xFFFF to 0.
- **Load condition:** load = en_i & (~m_axis_phase_tvalid | m_axis_phase_tready).
- **On load with resync_r = 0**
  - Output phase = (acc + offset_r) mod 2^30.
  - acc <= (acc + pinc_r) mod 2^30.
  - tuser <= 0.
- **On load with resync_r = 1**
  - Output phase = offset_r.
  - acc <= 0.
  - tuser <= 1.
  - Net effect: while resync is held, output stays at the offset. The first load after resync clears yields offset_r, then offset_r + pinc_r.
- **Output**
  - m_axis_phase_tdata <= phase[29:30-OUT_BITS]; tvalid <= 1 on load.
  - If there is no load and tready = 1, tvalid <= 0.
  - If there is no load and tready = 0, tdata, tuser and tvalid hold.
- **en_i low**
  - acc holds and no new samples are produced.
  - A pending valid sample stays asserted until it is accepted; tvalid never drops without a handshake.
- **Simultaneous config beat and load:** the load uses the register values from before the edge. The new beat affects loads from the next cycle on.
- **Reset (asynchronous, any time, including mid-stream)**
  - Clears acc, pinc_r, offset_r, resync_r, both counters, tdata, tuser, tvalid and s_axis_config_tready.
  - Every output is 0 during reset.

## Timing
- Config-to-effect: a beat accepted at edge N is first used by a load at edge N+1.
- Output latency: one cycle. A load at edge N shows tvalid = 1 with its sample after edge N.
- Throughput: one sample per clock while en_i = 1 and tready = 1.
- Backpressure: when tready = 0 with tvalid = 1, no load occurs and acc freezes. Phase continuity is kept across stalls, with no skipped or duplicated samples.
- Reset release: tready rises after the first edge; the first sample appears one edge after the first load.

## Test plan
- **Reset and config:** after reset, send pinc = 0x0100_0000, offset = 0 with en_i = 1 and tready = 1 -> outputs (OUT_BITS = 16) read 0x0000, 0x0400, 0x0800, ...; cfg_beats_o = 1.
- **Wrap:** pinc = 0x2000_0000 -> tdata sequence 0x0000, 0x8000, 0x0000, 0x8000 (accumulator wraps mod 2^30).
- **Offset and resync:** offset = 0x2000_0000 with resync = 1 held 3 beats, then resync = 0 with pinc = 0x0100_0000 -> 0x8000 three times with tuser = 1, then 0x8000, 0x8400 with tuser = 0.
- **Backpressure:** drop tready for 5 cycles mid-stream -> tdata and tvalid hold; when tready returns, the sequence resumes with no gaps or repeats.
- **Counters and en_i:** send 4 beats with tlast on the 4th while en_i = 0 -> cfg_beats_o = 4, cfg_packets_o = 1, no tvalid. Preload cfg_beats_o to 0xFFFF and send one beat -> it wraps to 0.
- **Reset mid-stream:** assert resetn_i low asynchronously (between edges) during streaming -> all outputs drop to 0 immediately; after release, output restarts at 0 with pinc = 0.

Source files
------------

// File: rtl/dds_phase_engine.sv
// DDS phase source: takes config beats (pinc/offset/resync) and streams truncated accumulator phase.
// One-cycle load-to-valid latency; tready low with a pending sample stalls the accumulator and holds the output.
module dds_phase_engine #(
  parameter int OUT_BITS = 16
) (
  input  logic                clk_i,
  input  logic                resetn_i,
  input  logic                en_i,
  input  logic [71:0]         s_axis_config_tdata,
  input  logic                s_axis_config_tvalid,
  input  logic                s_axis_config_tlast,
  output logic                s_axis_config_tready,
  output logic [OUT_BITS-1:0] m_axis_phase_tdata,
  output logic                m_axis_phase_tuser,
  output logic                m_axis_phase_tvalid,
  input  logic                m_axis_phase_tready,
  output logic [15:0]         cfg_beats_o,
  output logic [15:0]         cfg_packets_o
);

  // Width is pinned by the 72-bit config word layout.
  localparam int PHASE_BITS = 30;

  logic [PHASE_BITS-1:0] acc;
  logic [PHASE_BITS-1:0] pinc_r;
  logic [PHASE_BITS-1:0] offset_r;
  logic [PHASE_BITS-1:0] phase_nxt;
  logic                  resync_r;
  logic                  cfg_acc;
  logic                  load;
  logic                  unused_bits;

  assign unused_bits = ^{s_axis_config_tdata[71:65], s_axis_config_tdata[63:62],
                         s_axis_config_tdata[31:30], phase_nxt[PHASE_BITS-OUT_BITS-1:0]};

  assign cfg_acc   = s_axis_config_tvalid & s_axis_config_tready;
  assign load      = en_i & (~m_axis_phase_tvalid | m_axis_phase_tready);
  assign phase_nxt = resync_r ? offset_r : acc + offset_r;

  // A beat landing on the same edge as a load only affects later loads.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      s_axis_config_tready <= 1'b0;
      pinc_r               <= '0;
      offset_r             <= '0;
      resync_r             <= 1'b0;
      cfg_beats_o          <= '0;
      cfg_packets_o        <= '0;
    end else begin
      s_axis_config_tready <= 1'b1;
      if (cfg_acc) begin
        pinc_r      <= s_axis_config_tdata[PHASE_BITS-1:0];
        offset_r    <= s_axis_config_tdata[32+PHASE_BITS-1:32];
        resync_r    <= s_axis_config_tdata[64];
        cfg_beats_o <= cfg_beats_o + 16'd1;
        if (s_axis_config_tlast) begin
          cfg_packets_o <= cfg_packets_o + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      acc                 <= '0;
      m_axis_phase_tdata  <= '0;
      m_axis_phase_tuser  <= 1'b0;
      m_axis_phase_tvalid <= 1'b0;
    end else if (load) begin
      acc                 <= resync_r ? '0 : acc + pinc_r;
      m_axis_phase_tdata  <= phase_nxt[PHASE_BITS-1:PHASE_BITS-OUT_BITS];
      m_axis_phase_tuser  <= resync_r;
      m_axis_phase_tvalid <= 1'b1;
    end else if (m_axis_phase_tready) begin
      m_axis_phase_tvalid <= 1'b0;
    end
  end

endmodule
